idecode_sb: RTL and testbench
=============================

# idecode_sb

Parametrised decode stage with integrated register file, per-register pending-write scoreboard and registered ID/EX outputs. It sits between the IF/ID bridge and the execute stage. It replaces the purely combinational decode: it detects RAW hazards, stalls fetch, inserts bubbles and resolves BEQ/BLT branches only for issued instructions. It takes the WB write-back port as feedback.

## Interface
- `DATA_W`, 32: register / ALU data width.
- `NREG`, 32: number of registers (8, 16 or 32); register fields are 5 bits, low `$clog2(NREG)` bits used.
- `PC_W`, 32: program-counter width.
- `PEND_W`, 2: width of each scoreboard pending counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: `id_inst` / `pc_plus_1` hold a valid instruction.
- `id_inst` in 32: instruction. Fields: [31] wmem_en, [30] wreg_en, [29:25] reg1, [24:20] reg2, [19:15] wreg, [14:11] alu_op, [10] alu_src, [9] branch, [8] br_type, [7:0] imm8.
- `pc_plus_1` in PC_W: PC of the instruction plus 1.
- `wb_wena` in 1, `wb_waddr` in 5, `wb_wdata` in DATA_W: write-back port.
- `stall_out` out 1: hold PC and the IF/ID bridge.
- `pcsrc` out 1, `branch_target` out PC_W: taken branch and its target (combinational).
- `flush_if` out 1: squash the instruction currently in IF.
- `ex_valid` out 1; `ex_r1data`, `ex_r2data`, `ex_imm` out DATA_W; `ex_wreg` out 5; `ex_wreg_en`, `ex_wmem_en`, `ex_mem_read`, `ex_mem_to_reg`, `ex_alu_src` out 1; `ex_shift` out 5; `ex_alu_ctrl` out 4: ID/EX register.

## Operation
- Register file: `NREG` x `DATA_W`. Written on `clk` when `wb_wena` is high. Reads are asynchronous.
- Decoded control signals:
  - imm = imm8 sign-extended to DATA_W.
  - shift = imm8[4:0].
  - load = wreg_en & ~wmem_en & (alu_op == 4'hF).
  - mem_read = mem_to_reg = load.
- Source usage: reg1 is always used. reg2 is used when ~alu_src | branch | wmem_en.
- Scoreboard: one `PEND_W`-bit counter per register.
  - +1 when an instruction with wreg_en issues to that wreg.
  - -1 on a `wb_wena` write to that register.
  - Both in the same cycle: counter unchanged.
  - A decrement at 0 is ignored.
- Hazard: a used source has a nonzero counter, or wreg_en and the counter of wreg is at max (2^PEND_W - 1).
- `stall_out` = id_valid & hazard.
- issue = id_valid & ~hazard.
- ID/EX register:
  - On issue: loads all decoded fields and `ex_valid` = 1.
  - Otherwise: bubble; `ex_valid` = 0, `ex_wreg_en` = 0, `ex_wmem_en` = 0, `ex_mem_read` = 0.
- Branch:
  - taken = issue & branch & (br_type ? signed(r1) < signed(r2) : r1 == r2).
  - `pcsrc` = `flush_if` = taken.
  - `branch_target` = pc_plus_1 + imm, truncated to PC_W (wrap-around).
- Register 0 has no special meaning.

## Timing
- Decode-to-EX latency: 1 cycle. Outputs appear on the edge where issue = 1.
- `stall_out`, `pcsrc`, `flush_if` and `branch_target` are combinational in the decode cycle.
- Reset: all ex_* outputs = 0, all counters = 0, all registers = 0.
  - Reset mid-stall drops all pending state. The next valid instruction issues without a stall.
- Reset has priority over a write-back in the same cycle.
- Simultaneous WB write and read of the same register: see Configuration.
- A stalled instruction must hold `id_inst` stable. The block does not latch it.

## Configuration
- `IDECODE_WB_BYPASS_EN` defined:
  - Reads return `wb_wdata` when `wb_wena` is high and `wb_waddr` equals the read address.
  - A source whose counter is 1 and is being written back this cycle is not a hazard.
  - A RAW dependency resolves in the WB cycle itself.
- Undefined:
  - Reads return the stored value.
  - The stall persists until the counter is 0, i.e. one cycle after write-back.

## Test plan
- Reset, then issue `id_inst` with reg1=1, reg2=2, wreg=3, wreg_en=1, alu_src=0 -> next cycle `ex_valid`=1, `ex_wreg`=3, `ex_r1data`=`ex_r2data`=0; counter[3]=1.
- Producer to r3, then consumer reading r3; write-back 3 cycles later with data 0x55 -> `stall_out` high until the WB cycle (bypass) or WB+1 (no bypass); consumer issues with `ex_r1data`=0x55; bubbles have `ex_valid`=0.
- BLT with r1=-1 (0xFFFFFFFF), r2=1, imm8=0xFE, pc_plus_1=0x10 -> `pcsrc`=`flush_if`=1, `branch_target`=0x0E. BEQ with unequal operands -> `pcsrc`=0.
- Branch whose source is pending -> `pcsrc` stays 0 while `stall_out`=1; `pcsrc` asserts on the issue cycle only.
- Four back-to-back writers to r5 with PEND_W=2 and no WB -> the fourth stalls (counter 3). One WB to r5 -> the fourth issues the next cycle.
- Assert `rst` while stalled with counters nonzero -> next cycle all counters 0 and all ex_* = 0; the held instruction issues without a stall.

Source files
------------

// File: rtl/idecode_sb_if.sv
// Decode-stage bundle: IF/ID inputs, write-back feedback, hazard/branch outputs and ID/EX register.
// The master side drives the instruction and write-back fields; the slave side is the decode stage.
interface idecode_sb_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [PC_W-1:0]   pc_plus_1;
  logic              wb_wena;
  logic [4:0]        wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              stall_out;
  logic              pcsrc;
  logic              flush_if;
  logic [PC_W-1:0]   branch_target;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_r1data;
  logic [DATA_W-1:0] ex_r2data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_wreg;
  logic              ex_wreg_en;
  logic              ex_wmem_en;
  logic              ex_mem_read;
  logic              ex_mem_to_reg;
  logic              ex_alu_src;
  logic [4:0]        ex_shift;
  logic [3:0]        ex_alu_ctrl;

  modport master (
    output id_valid, id_inst, pc_plus_1, wb_wena, wb_waddr, wb_wdata,
    input  stall_out, pcsrc, flush_if, branch_target,
    input  ex_valid, ex_r1data, ex_r2data, ex_imm, ex_wreg, ex_wreg_en, ex_wmem_en,
    input  ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_shift, ex_alu_ctrl
  );

  modport slave (
    input  id_valid, id_inst, pc_plus_1, wb_wena, wb_waddr, wb_wdata,
    output stall_out, pcsrc, flush_if, branch_target,
    output ex_valid, ex_r1data, ex_r2data, ex_imm, ex_wreg, ex_wreg_en, ex_wmem_en,
    output ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_shift, ex_alu_ctrl
  );
endinterface

// File: rtl/idecode_sb.sv
// Decode stage with register file, per-register pending-write scoreboard and ID/EX register.
// Define IDECODE_WB_BYPASS_EN to forward the write-back value and resolve RAW hazards in the WB cycle.
module idecode_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int PC_W   = 32,
  parameter int PEND_W = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  idecode_sb_if.slave bus
);
  localparam int RA_W = $clog2(NREG);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [NREG-1:0]   inc_v, dec_v;

  logic              ex_valid_q, ex_wreg_en_q, ex_wmem_en_q, ex_mem_read_q;
  logic              ex_mem_to_reg_q, ex_alu_src_q;
  logic [DATA_W-1:0] ex_r1data_q, ex_r2data_q, ex_imm_q;
  logic [4:0]        ex_wreg_q, ex_shift_q;
  logic [3:0]        ex_alu_ctrl_q;

  logic              wmem_en, wreg_en, alu_src, branch, br_type, load, use_r2;
  logic [3:0]        alu_op;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   imm_pc;
  logic [RA_W-1:0]   r1_a, r2_a, wr_a, wb_a;
  logic [DATA_W-1:0] r1_data, r2_data;
  logic              r1_busy, r2_busy, hazard, issue, br_cond, taken;

  assign wmem_en = bus.id_inst[31];
  assign wreg_en = bus.id_inst[30];
  assign r1_a    = bus.id_inst[25 +: RA_W];
  assign r2_a    = bus.id_inst[20 +: RA_W];
  assign wr_a    = bus.id_inst[15 +: RA_W];
  assign alu_op  = bus.id_inst[14:11];
  assign alu_src = bus.id_inst[10];
  assign branch  = bus.id_inst[9];
  assign br_type = bus.id_inst[8];
  assign imm8    = bus.id_inst[7:0];
  assign wb_a    = bus.wb_waddr[RA_W-1:0];

  assign imm_ext = {{(DATA_W-8){imm8[7]}}, imm8};
  assign imm_pc  = {{(PC_W-8){imm8[7]}}, imm8};
  assign load    = wreg_en & ~wmem_en & (alu_op == 4'hF);
  assign use_r2  = ~alu_src | branch | wmem_en;

  always_comb begin
    r1_data = regs_q[r1_a];
    r2_data = regs_q[r2_a];
    r1_busy = (pend_q[r1_a] != '0);
    r2_busy = (pend_q[r2_a] != '0);
`ifdef IDECODE_WB_BYPASS_EN
    // The last outstanding write landing this cycle satisfies the reader directly.
    if (bus.wb_wena && (wb_a == r1_a)) begin
      r1_data = bus.wb_wdata;
      if (pend_q[r1_a] == PEND_ONE) r1_busy = 1'b0;
    end
    if (bus.wb_wena && (wb_a == r2_a)) begin
      r2_data = bus.wb_wdata;
      if (pend_q[r2_a] == PEND_ONE) r2_busy = 1'b0;
    end
`endif
  end

  assign hazard  = r1_busy | (use_r2 & r2_busy) | (wreg_en & (pend_q[wr_a] == PEND_MAX));
  assign issue   = bus.id_valid & ~hazard;
  assign br_cond = br_type ? ($signed(r1_data) < $signed(r2_data)) : (r1_data == r2_data);
  assign taken   = issue & branch & br_cond;

  assign bus.stall_out     = bus.id_valid & hazard;
  assign bus.pcsrc         = taken;
  assign bus.flush_if      = taken;
  assign bus.branch_target = bus.pc_plus_1 + imm_pc;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      inc_v[i]  = issue & wreg_en & (wr_a == RA_W'(i));
      dec_v[i]  = bus.wb_wena & (wb_a == RA_W'(i)) & (pend_q[i] != '0);
      pend_d[i] = pend_q[i];
      if (inc_v[i] && !dec_v[i])      pend_d[i] = pend_q[i] + PEND_ONE;
      else if (dec_v[i] && !inc_v[i]) pend_d[i] = pend_q[i] - PEND_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      ex_valid_q      <= 1'b0;
      ex_wreg_en_q    <= 1'b0;
      ex_wmem_en_q    <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_r1data_q     <= '0;
      ex_r2data_q     <= '0;
      ex_imm_q        <= '0;
      ex_wreg_q       <= '0;
      ex_shift_q      <= '0;
      ex_alu_ctrl_q   <= '0;
    end else begin
      if (bus.wb_wena) regs_q[wb_a] <= bus.wb_wdata;
      for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
      if (issue) begin
        ex_valid_q      <= 1'b1;
        ex_wreg_en_q    <= wreg_en;
        ex_wmem_en_q    <= wmem_en;
        ex_mem_read_q   <= load;
        ex_mem_to_reg_q <= load;
        ex_alu_src_q    <= alu_src;
        ex_r1data_q     <= r1_data;
        ex_r2data_q     <= r2_data;
        ex_imm_q        <= imm_ext;
        ex_wreg_q       <= bus.id_inst[19:15];
        ex_shift_q      <= imm8[4:0];
        ex_alu_ctrl_q   <= alu_op;
      end else begin
        // Bubble: only the side-effecting controls are cleared, the datapath fields hold.
        ex_valid_q    <= 1'b0;
        ex_wreg_en_q  <= 1'b0;
        ex_wmem_en_q  <= 1'b0;
        ex_mem_read_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_wreg_en    = ex_wreg_en_q;
  assign bus.ex_wmem_en    = ex_wmem_en_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
  assign bus.ex_alu_src    = ex_alu_src_q;
  assign bus.ex_r1data     = ex_r1data_q;
  assign bus.ex_r2data     = ex_r2data_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_wreg       = ex_wreg_q;
  assign bus.ex_shift      = ex_shift_q;
  assign bus.ex_alu_ctrl   = ex_alu_ctrl_q;
endmodule

// File: tb/tb_idecode_sb.sv
// Bench for idecode_sb: directed scenarios plus random instruction streams against an
// array/queue model of the register file and pending-write counts.
module tb_idecode_sb;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  idecode_sb_if #(.DATA_W(32), .PC_W(32)) bus ();
  idecode_sb #(.DATA_W(32), .NREG(32), .PC_W(32), .PEND_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef IDECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [31:0] p_r1, p_r2;
  logic        p_issue;
  logic        e_stall, e_taken;
  logic [31:0] e_target;
  logic        e_valid, e_wreg_en, e_wmem_en, e_mem_read, e_mem_to_reg, e_alu_src;
  logic [31:0] e_r1, e_r2, e_imm;
  logic [4:0]  e_wreg, e_shift;
  logic [3:0]  e_alu_ctrl;

  function automatic logic [31:0] mk(input logic wm, input logic we, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [4:0] wr,
                                     input logic [3:0] op, input logic asrc, input logic br,
                                     input logic brt, input logic [7:0] imm);
    return {wm, we, r1, r2, wr, op, asrc, br, brt, imm};
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] a);
    if (BYP && bus.wb_wena && bus.wb_waddr == a) return bus.wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic busy(input logic [4:0] a);
    if (m_pend[a] == 0) return 1'b0;
    if (BYP && m_pend[a] == 1 && bus.wb_wena && bus.wb_waddr == a) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_pre();
    logic [31:0] ins;
    logic        use2, hz, cond;
    ins     = bus.id_inst;
    use2    = !ins[10] || ins[9] || ins[31];
    p_r1    = rd(ins[29:25]);
    p_r2    = rd(ins[24:20]);
    hz      = busy(ins[29:25]) || (use2 && busy(ins[24:20])) ||
              (ins[30] && m_pend[ins[19:15]] == PMAX);
    e_stall = bus.id_valid && hz;
    p_issue = bus.id_valid && !hz;
    cond    = ins[8] ? ($signed(p_r1) < $signed(p_r2)) : (p_r1 == p_r2);
    e_taken = p_issue && ins[9] && cond;
    e_target = bus.pc_plus_1 + {{24{ins[7]}}, ins[7:0]};
  endtask

  task automatic model_post();
    logic [31:0] ins;
    logic        dec;
    ins = bus.id_inst;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      {e_valid, e_wreg_en, e_wmem_en, e_mem_read, e_mem_to_reg, e_alu_src} = '0;
      e_r1 = '0; e_r2 = '0; e_imm = '0; e_wreg = '0; e_shift = '0; e_alu_ctrl = '0;
      return;
    end
    if (p_issue) begin
      e_valid = 1'b1; e_wreg_en = ins[30]; e_wmem_en = ins[31];
      e_mem_read = ins[30] && !ins[31] && ins[14:11] == 4'hF;
      e_mem_to_reg = e_mem_read; e_alu_src = ins[10];
      e_r1 = p_r1; e_r2 = p_r2; e_imm = {{24{ins[7]}}, ins[7:0]};
      e_wreg = ins[19:15]; e_shift = ins[4:0]; e_alu_ctrl = ins[14:11];
    end else begin
      e_valid = 1'b0; e_wreg_en = 1'b0; e_wmem_en = 1'b0; e_mem_read = 1'b0;
    end
    dec = bus.wb_wena && m_pend[bus.wb_waddr] > 0;
    if (dec) m_pend[bus.wb_waddr] -= 1;
    if (p_issue && ins[30]) m_pend[ins[19:15]] += 1;
    if (bus.wb_wena) m_regs[bus.wb_waddr] = bus.wb_wdata;
  endtask

  task automatic tick();
    model_pre();
    @(posedge clk);
    model_post();
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid = 1'b0; bus.id_inst = '0; bus.pc_plus_1 = '0;
    bus.wb_wena = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wb_preload(input logic [4:0] a, input logic [31:0] d);
    bus.wb_wena = 1'b1; bus.wb_waddr = a; bus.wb_wdata = d;
    tick();
    bus.wb_wena = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    bus.wb_wena = 1'b1; bus.wb_waddr = 5'd9; bus.wb_wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_r1data !== 32'h0) begin bad++; $display("FAIL reset_ex_r1data got=%0h want=0", bus.ex_r1data); end
    total++; if (bus.ex_alu_ctrl !== 4'h0) begin bad++; $display("FAIL reset_ex_alu_ctrl got=%0h want=0", bus.ex_alu_ctrl); end
    bus.id_valid = 1'b1; bus.id_inst = mk(0, 0, 5'd9, 5'd0, 5'd0, 4'h1, 1, 0, 0, 8'h00);
    tick();
    total++; if (bus.ex_r1data !== 32'h0) begin bad++; $display("FAIL reset_beats_wb got=%0h want=0", bus.ex_r1data); end
    set_idle();
  endtask

  task automatic test_basic_issue();
    do_reset();
    bus.id_valid = 1'b1;
    bus.id_inst = mk(0, 1, 5'd1, 5'd2, 5'd3, 4'h2, 0, 0, 0, 8'h87);
    #1;
    total++; if (bus.stall_out !== 1'b0) begin bad++; $display("FAIL basic_stall got=%0b want=0", bus.stall_out); end
    tick();
    bus.id_valid = 1'b0;
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL basic_ex_valid got=%0b want=1", bus.ex_valid); end
    total++; if (bus.ex_wreg !== 5'd3) begin bad++; $display("FAIL basic_ex_wreg got=%0d want=3", bus.ex_wreg); end
    total++; if (bus.ex_r1data !== 32'h0 || bus.ex_r2data !== 32'h0) begin bad++; $display("FAIL basic_rdata got=%0h/%0h want=0/0", bus.ex_r1data, bus.ex_r2data); end
    total++; if (bus.ex_imm !== 32'hFFFF_FF87 || bus.ex_shift !== 5'd7) begin bad++; $display("FAIL basic_imm got=%0h/%0h want=ffffff87/7", bus.ex_imm, bus.ex_shift); end
    total++; if (dut.pend_q[3] !== 2'd1) begin bad++; $display("FAIL basic_pend3 got=%0d want=1", dut.pend_q[3]); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_wreg_en !== 1'b0) begin bad++; $display("FAIL basic_bubble got=%0b%0b want=00", bus.ex_valid, bus.ex_wreg_en); end
  endtask

  task automatic test_raw_stall();
    int issue_c;
    issue_c = BYP ? 3 : 4;
    do_reset();
    bus.id_valid = 1'b1;
    bus.id_inst = mk(0, 1, 5'd0, 5'd0, 5'd3, 4'h1, 1, 0, 0, 8'h01);
    tick();
    bus.id_inst = mk(0, 0, 5'd3, 5'd0, 5'd0, 4'h2, 1, 0, 0, 8'h00);
    for (int c = 1; c <= issue_c; c++) begin
      bus.wb_wena = (c == 3); bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h55;
      #1;
      total++; if (bus.stall_out !== (c < issue_c)) begin bad++; $display("FAIL raw_stall c=%0d got=%0b want=%0b", c, bus.stall_out, c < issue_c); end
      tick();
      total++; if (bus.ex_valid !== (c == issue_c)) begin bad++; $display("FAIL raw_ex_valid c=%0d got=%0b want=%0b", c, bus.ex_valid, c == issue_c); end
    end
    total++; if (bus.ex_r1data !== 32'h55) begin bad++; $display("FAIL raw_r1data got=%0h want=55", bus.ex_r1data); end
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    wb_preload(5'd1, 32'hFFFF_FFFF);
    wb_preload(5'd2, 32'h1);
    bus.id_valid = 1'b1; bus.pc_plus_1 = 32'h10;
    bus.id_inst = mk(0, 0, 5'd1, 5'd2, 5'd0, 4'h0, 0, 1, 1, 8'hFE);
    #1;
    total++; if (bus.pcsrc !== 1'b1 || bus.flush_if !== 1'b1) begin bad++; $display("FAIL blt_taken got=%0b%0b want=11", bus.pcsrc, bus.flush_if); end
    total++; if (bus.branch_target !== 32'h0E) begin bad++; $display("FAIL blt_target got=%0h want=e", bus.branch_target); end
    tick();
    bus.id_inst = mk(0, 0, 5'd1, 5'd2, 5'd0, 4'h0, 0, 1, 0, 8'h04);
    #1;
    total++; if (bus.pcsrc !== 1'b0 || bus.flush_if !== 1'b0) begin bad++; $display("FAIL beq_ne got=%0b%0b want=00", bus.pcsrc, bus.flush_if); end
    tick();
    bus.id_inst = mk(0, 0, 5'd2, 5'd1, 5'd0, 4'h0, 0, 1, 1, 8'h04);
    #1;
    total++; if (bus.pcsrc !== 1'b0) begin bad++; $display("FAIL blt_not_less got=%0b want=0", bus.pcsrc); end
    tick();
    bus.id_inst = mk(0, 0, 5'd2, 5'd2, 5'd0, 4'h0, 0, 1, 0, 8'h7F);
    #1;
    total++; if (bus.pcsrc !== 1'b1 || bus.branch_target !== 32'h8F) begin bad++; $display("FAIL beq_eq got=%0b/%0h want=1/8f", bus.pcsrc, bus.branch_target); end
    tick();
    set_idle();
  endtask

  task automatic test_branch_pending();
    int issue_c;
    issue_c = BYP ? 2 : 3;
    do_reset();
    wb_preload(5'd4, 32'h7);
    bus.id_valid = 1'b1;
    bus.id_inst = mk(0, 1, 5'd0, 5'd0, 5'd4, 4'h1, 1, 0, 0, 8'h00);
    tick();
    bus.pc_plus_1 = 32'h20;
    bus.id_inst = mk(0, 0, 5'd4, 5'd4, 5'd0, 4'h0, 0, 1, 0, 8'h04);
    for (int c = 1; c <= issue_c; c++) begin
      bus.wb_wena = (c == 2); bus.wb_waddr = 5'd4; bus.wb_wdata = 32'h9;
      #1;
      total++; if (bus.pcsrc !== (c == issue_c) || bus.stall_out !== (c < issue_c)) begin bad++; $display("FAIL brpend c=%0d got=%0b%0b want=%0b%0b", c, bus.pcsrc, bus.stall_out, c == issue_c, c < issue_c); end
      if (c == issue_c) begin
        total++; if (bus.branch_target !== 32'h24) begin bad++; $display("FAIL brpend_target got=%0h want=24", bus.branch_target); end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_pend_sat();
    do_reset();
    bus.id_valid = 1'b1;
    bus.id_inst = mk(0, 1, 5'd0, 5'd0, 5'd5, 4'h3, 1, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) tick();
    total++; if (dut.pend_q[5] !== 2'd3) begin bad++; $display("FAIL sat_pend got=%0d want=3", dut.pend_q[5]); end
    #1;
    total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL sat_stall4 got=%0b want=1", bus.stall_out); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL sat_bubble got=%0b want=0", bus.ex_valid); end
    bus.wb_wena = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hA5;
    #1;
    total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL sat_wb_cycle got=%0b want=1", bus.stall_out); end
    tick();
    bus.wb_wena = 1'b0;
    #1;
    total++; if (bus.stall_out !== 1'b0) begin bad++; $display("FAIL sat_release got=%0b want=0", bus.stall_out); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_wreg !== 5'd5) begin bad++; $display("FAIL sat_issue got=%0b/%0d want=1/5", bus.ex_valid, bus.ex_wreg); end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.id_valid = 1'b1;
    bus.id_inst = mk(0, 1, 5'd0, 5'd0, 5'd6, 4'h9, 1, 0, 0, 8'h13);
    tick();
    bus.id_inst = mk(0, 1, 5'd6, 5'd0, 5'd7, 4'h4, 1, 0, 0, 8'h02);
    #1;
    total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL rstmid_stall got=%0b want=1", bus.stall_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (dut.pend_q[6] !== 2'd0) begin bad++; $display("FAIL rstmid_pend got=%0d want=0", dut.pend_q[6]); end
    total++; if ({bus.ex_valid, bus.ex_wreg_en, bus.ex_wreg, bus.ex_alu_ctrl, bus.ex_imm} !== '0) begin bad++; $display("FAIL rstmid_ex got=%0b/%0d/%0h/%0h want=0", bus.ex_valid, bus.ex_wreg, bus.ex_alu_ctrl, bus.ex_imm); end
    #1;
    total++; if (bus.stall_out !== 1'b0) begin bad++; $display("FAIL rstmid_nostall got=%0b want=0", bus.stall_out); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_wreg !== 5'd7) begin bad++; $display("FAIL rstmid_issue got=%0b/%0d want=1/7", bus.ex_valid, bus.ex_wreg); end
    set_idle();
  endtask

  task automatic test_random();
    logic [4:0] wq[$];
    logic       held;
    logic       push;
    logic [4:0] push_r;
    do_reset();
    held = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!held) begin
        bus.id_valid  = ($urandom_range(0, 3) != 0);
        bus.pc_plus_1 = $urandom;
        bus.id_inst   = mk($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)),
                           ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                           1'($urandom_range(0, 1)), 8'($urandom));
      end
      if (wq.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.wb_wena = 1'b1; bus.wb_waddr = wq.pop_front(); bus.wb_wdata = $urandom;
      end else begin
        bus.wb_wena = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
      end
      #1;
      model_pre();
      total++; if (bus.stall_out !== e_stall) begin bad++; $display("FAIL rand_stall n=%0d got=%0b want=%0b", n, bus.stall_out, e_stall); end
      total++; if (bus.pcsrc !== e_taken || bus.flush_if !== e_taken) begin bad++; $display("FAIL rand_pcsrc n=%0d got=%0b%0b want=%0b", n, bus.pcsrc, bus.flush_if, e_taken); end
      if (e_taken) begin
        total++; if (bus.branch_target !== e_target) begin bad++; $display("FAIL rand_target n=%0d got=%0h want=%0h", n, bus.branch_target, e_target); end
      end
      push = p_issue && bus.id_inst[30];
      push_r = bus.id_inst[19:15];
      held = e_stall;
      tick();
      if (push) wq.push_back(push_r);
      total++; if ({bus.ex_valid, bus.ex_wreg_en, bus.ex_wmem_en, bus.ex_mem_read} !== {e_valid, e_wreg_en, e_wmem_en, e_mem_read}) begin
        bad++; $display("FAIL rand_ctl n=%0d got=%0b%0b%0b%0b want=%0b%0b%0b%0b", n, bus.ex_valid, bus.ex_wreg_en, bus.ex_wmem_en, bus.ex_mem_read, e_valid, e_wreg_en, e_wmem_en, e_mem_read);
      end
      if (e_valid) begin
        total++; if ({bus.ex_r1data, bus.ex_r2data, bus.ex_imm, bus.ex_wreg, bus.ex_shift, bus.ex_alu_ctrl, bus.ex_alu_src, bus.ex_mem_to_reg} !==
                     {e_r1, e_r2, e_imm, e_wreg, e_shift, e_alu_ctrl, e_alu_src, e_mem_to_reg}) begin
          bad++; $display("FAIL rand_data n=%0d got=%0h %0h %0h %0d %0d %0h %0b%0b want=%0h %0h %0h %0d %0d %0h %0b%0b", n,
                          bus.ex_r1data, bus.ex_r2data, bus.ex_imm, bus.ex_wreg, bus.ex_shift, bus.ex_alu_ctrl, bus.ex_alu_src, bus.ex_mem_to_reg,
                          e_r1, e_r2, e_imm, e_wreg, e_shift, e_alu_ctrl, e_alu_src, e_mem_to_reg);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_branch();
    test_branch_pending();
    test_pend_sat();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
